// File: rtl/mmu_wrr_arbiter_pkg.sv
// Shared MMU arbiter types: default widths and the mux-ordering entry
// consumed by the host and card data-path mux logic.
package lynxTypes;

    localparam int MMU_ARB_WEIGHT_BITS = 4;
    localparam int MMU_ARB_MAX_OUT     = 16;

    localparam int MUX_ORD_ID_BITS  = 8;
    localparam int MUX_ORD_LEN_BITS = 28;

    typedef struct packed {
        logic [MUX_ORD_ID_BITS-1:0]  id;
        logic [MUX_ORD_LEN_BITS-1:0] len;
    } mux_ord_t;

endpackage

// File: rtl/mmu_wrr_arbiter_sel.sv
// Rotating-priority picker: returns the first set bit of the eligible
// vector at or after the start index, wrapping around.
module mmu_wrr_sel #(
    parameter int N_CH    = 4,
    parameter int ID_BITS = 2
) (
    input  logic [N_CH-1:0]    eligible,
    input  logic [ID_BITS-1:0] start,
    output logic               found,
    output logic [ID_BITS-1:0] idx
);

    int unsigned     pos;
    logic [N_CH-1:0] rot;

    // Walk from the far end back towards start so the closest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        pos   = 0;
        rot   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            pos = (int'(start) + k) % N_CH;
            rot = eligible >> pos;
            if (rot[0]) begin
                found = 1'b1;
                idx   = ID_BITS'(pos);
            end
        end
    end

endmodule

// File: rtl/mmu_wrr_arbiter.sv
// Weighted round-robin merge of per-region MMU DMA requests with per-channel
// outstanding limits and a paired mux-ordering entry for every grant.
module mmu_wrr_arbiter
    import lynxTypes::*;
#(
    parameter  int N_CH        = 4,
    parameter  int REQ_BITS    = 128,
    parameter  int LEN_BITS    = 28,
    parameter  int WEIGHT_BITS = MMU_ARB_WEIGHT_BITS,
    parameter  int MAX_OUT     = MMU_ARB_MAX_OUT,
    localparam int CNT_BITS    = $clog2(MAX_OUT + 1),
    localparam int ID_BITS     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [N_CH-1:0]                     s_req_valid,
    output logic [N_CH-1:0]                     s_req_ready,
    input  logic [N_CH-1:0][REQ_BITS-1:0]       s_req_data,
    input  logic [N_CH-1:0][LEN_BITS-1:0]       s_req_len,
    input  logic [N_CH-1:0]                     s_done,
    input  logic [N_CH-1:0][WEIGHT_BITS-1:0]    cfg_weight,
    output logic                                m_req_valid,
    input  logic                                m_req_ready,
    output logic [REQ_BITS-1:0]                 m_req_data,
    output logic                                m_mux_valid,
    input  logic                                m_mux_ready,
    output logic [ID_BITS-1:0]                  m_mux_id,
    output logic [LEN_BITS-1:0]                 m_mux_len,
    output logic [N_CH-1:0][CNT_BITS-1:0]       outstanding,
    output logic [N_CH-1:0]                     err_underflow
);

    logic [ID_BITS-1:0]     cur;
    logic [ID_BITS-1:0]     start;
    logic [ID_BITS-1:0]     sel_idx;
    logic [ID_BITS-1:0]     grant_idx;
    logic [WEIGHT_BITS-1:0] bcnt;
    logic                   req_pend;
    logic                   mux_pend;
    logic                   slot_free;
    logic                   sel_found;
    logic                   burst_cont;
    logic                   grant_valid;
    logic [N_CH-1:0]        eligible;
    logic [N_CH-1:0]        accept;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = s_req_valid[i] && (cfg_weight[i] != '0) &&
                          (outstanding[i] < CNT_BITS'(MAX_OUT));
        end
    end

    assign start = (cur == ID_BITS'(N_CH - 1)) ? '0 : cur + ID_BITS'(1);

    mmu_wrr_sel #(
        .N_CH    (N_CH),
        .ID_BITS (ID_BITS)
    ) u_sel (
        .eligible (eligible),
        .start    (start),
        .found    (sel_found),
        .idx      (sel_idx)
    );

    assign slot_free = (!req_pend || m_req_ready) && (!mux_pend || m_mux_ready);

    // bcnt==0 only out of reset: no burst is running yet, so search from cur+1.
    assign burst_cont  = eligible[cur] && (bcnt != '0) && (bcnt < cfg_weight[cur]);
    assign grant_valid = slot_free && (burst_cont || sel_found);
    assign grant_idx   = burst_cont ? cur : sel_idx;

    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = grant_valid && (grant_idx == ID_BITS'(i));
        end
    end

    assign s_req_ready = accept;
    assign m_req_valid = req_pend;
    assign m_mux_valid = mux_pend;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cur        <= ID_BITS'(N_CH - 1);
            bcnt       <= '0;
            req_pend   <= 1'b0;
            mux_pend   <= 1'b0;
            m_req_data <= '0;
            m_mux_id   <= '0;
            m_mux_len  <= '0;
        end else if (grant_valid) begin
            req_pend   <= 1'b1;
            mux_pend   <= 1'b1;
            m_req_data <= s_req_data[grant_idx];
            m_mux_id   <= grant_idx;
            m_mux_len  <= s_req_len[grant_idx];
            if (burst_cont) begin
                bcnt <= bcnt + WEIGHT_BITS'(1);
            end else begin
                cur  <= sel_idx;
                bcnt <= WEIGHT_BITS'(1);
            end
        end else begin
            if (m_req_ready) req_pend <= 1'b0;
            if (m_mux_ready) mux_pend <= 1'b0;
        end
    end

    // A done pulse that coincides with an accept cancels it out.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            outstanding   <= '0;
            err_underflow <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s_done[i] && (outstanding[i] == '0)) err_underflow[i] <= 1'b1;
                if (accept[i] && !s_done[i]) begin
                    outstanding[i] <= outstanding[i] + CNT_BITS'(1);
                end else if (!accept[i] && s_done[i] && (outstanding[i] != '0)) begin
                    outstanding[i] <= outstanding[i] - CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mmu_wrr_arbiter.sv
// Randomized and directed bench for mmu_wrr_arbiter, checked every cycle
// against a behavioural model of the weighted round-robin rules.
module tb_mmu_wrr_arbiter;

    localparam int N  = 4;
    localparam int RB = 16;
    localparam int LB = 8;
    localparam int WB = 4;
    localparam int MO = 3;
    localparam int CB = $clog2(MO + 1);
    localparam int IB = 2;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic [N-1:0]         s_req_valid;
    logic [N-1:0]         s_req_ready;
    logic [N-1:0][RB-1:0] s_req_data;
    logic [N-1:0][LB-1:0] s_req_len;
    logic [N-1:0]         s_done;
    logic [N-1:0][WB-1:0] cfg_weight;
    logic                 m_req_valid;
    logic                 m_req_ready;
    logic [RB-1:0]        m_req_data;
    logic                 m_mux_valid;
    logic                 m_mux_ready;
    logic [IB-1:0]        m_mux_id;
    logic [LB-1:0]        m_mux_len;
    logic [N-1:0][CB-1:0] outstanding;
    logic [N-1:0]         err_underflow;

    mmu_wrr_arbiter #(
        .N_CH        (N),
        .REQ_BITS    (RB),
        .LEN_BITS    (LB),
        .WEIGHT_BITS (WB),
        .MAX_OUT     (MO)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_req_data    (s_req_data),
        .s_req_len     (s_req_len),
        .s_done        (s_done),
        .cfg_weight    (cfg_weight),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_req_data    (m_req_data),
        .m_mux_valid   (m_mux_valid),
        .m_mux_ready   (m_mux_ready),
        .m_mux_id      (m_mux_id),
        .m_mux_len     (m_mux_len),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_grant;

    // behavioural model state
    int            m_cur;
    int            m_burst;
    bit            m_rp, m_mp;
    logic [RB-1:0] m_data;
    int            m_id;
    logic [LB-1:0] m_len;
    int            m_cnt [N];
    bit            m_err [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = N - 1; m_burst = 0; m_rp = 0; m_mp = 0;
        m_data = '0; m_id = 0; m_len = '0;
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_err[i] = 0; end
    endtask

    function automatic bit elig(input int c);
        return s_req_valid[c] && (cfg_weight[c] != 0) && (m_cnt[c] < MO);
    endfunction

    task automatic model_pick(output int g, output bit cont);
        g = -1; cont = 0;
        if ((m_rp && !m_req_ready) || (m_mp && !m_mux_ready)) return;
        if (m_burst > 0 && elig(m_cur) && m_burst < int'(cfg_weight[m_cur])) begin
            g = m_cur; cont = 1; return;
        end
        for (int k = 1; k <= N; k++) begin
            if (elig((m_cur + k) % N)) begin g = (m_cur + k) % N; return; end
        end
    endtask

    task automatic model_commit(input int g, input bit cont);
        for (int i = 0; i < N; i++) begin
            if (s_done[i] && m_cnt[i] == 0) m_err[i] = 1;
            if (g == i && !s_done[i]) m_cnt[i]++;
            else if (g != i && s_done[i] && m_cnt[i] > 0) m_cnt[i]--;
        end
        if (g >= 0) begin
            m_rp = 1; m_mp = 1;
            m_data = s_req_data[g]; m_id = g; m_len = s_req_len[g];
            if (cont) m_burst++;
            else begin m_cur = g; m_burst = 1; end
        end else begin
            if (m_req_ready) m_rp = 0;
            if (m_mux_ready) m_mp = 0;
        end
    endtask

    task automatic check_all(input int g);
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("s_req_ready", s_req_ready, exp_rdy);
        chk("m_req_valid", m_req_valid, m_rp);
        chk("m_req_data", m_req_data, m_data);
        chk("m_mux_valid", m_mux_valid, m_mp);
        chk("m_mux_id", m_mux_id, m_id);
        chk("m_mux_len", m_mux_len, m_len);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("outstanding[%0d]", i), outstanding[i], m_cnt[i]);
            chk($sformatf("err_underflow[%0d]", i), err_underflow[i], m_err[i]);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            s_req_data[i] = RB'($urandom);
            s_req_len[i]  = LB'($urandom);
        end
    endtask

    // Inputs are set by the caller shortly after a rising edge.
    task automatic step();
        int g;
        bit cont;
        #1;
        model_pick(g, cont);
        check_all(g);
        dut_grant = -1;
        for (int i = 0; i < N; i++) if (s_req_ready[i]) dut_grant = i;
        @(posedge aclk);
        model_commit(g, cont);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_req_valid = '0; s_done = '0;
        #1;
        chk("rst_s_req_ready", s_req_ready, 0);
        chk("rst_m_req_valid", m_req_valid, 0);
        chk("rst_m_req_data", m_req_data, 0);
        chk("rst_m_mux_valid", m_mux_valid, 0);
        chk("rst_m_mux_id", m_mux_id, 0);
        chk("rst_m_mux_len", m_mux_len, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_underflow", err_underflow, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
    endtask

    int exp_ord [8] = '{0, 0, 1, 2, 3, 0, 0, 1};

    initial begin
        areset = 1'b1;
        s_req_valid = '0; s_done = '0;
        cfg_weight = '0; m_req_ready = 1'b1; m_mux_ready = 1'b1;
        rand_payload();
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        do_reset();

        // weighted order with weights {2,1,1,1}
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd2};
        s_req_valid = '1; s_done = '1;
        for (int c = 0; c < 8; c++) begin
            rand_payload();
            step();
            chk($sformatf("order[%0d]", c), dut_grant, exp_ord[c]);
        end

        // weight zero disables channel 1
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd0, 4'd1};
        s_req_valid = '1; s_done = '1;
        for (int c = 0; c < 12; c++) begin
            rand_payload();
            step();
            chk("w0_grant1", dut_grant == 1, 0);
        end

        // outstanding limit on channel 0
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        s_req_valid = 4'b0001;
        repeat (3) begin rand_payload(); step(); end
        step();
        chk("lim_block", dut_grant, -1);
        chk("lim_cnt_full", outstanding[0], MO);
        s_done = 4'b0001;
        step();
        s_done = '0;
        chk("lim_cnt_dec", outstanding[0], MO - 1);
        step();
        chk("lim_resume", dut_grant, 0);

        // mux entry stalled while request side drains
        do_reset();
        s_req_valid = 4'b0010;
        m_mux_ready = 1'b0;
        rand_payload();
        step();
        for (int c = 0; c < 3; c++) begin
            rand_payload();
            step();
            chk("stall_nogrant", dut_grant, -1);
            chk("stall_id", m_mux_id, 1);
        end
        m_mux_ready = 1'b1;
        step();
        chk("stall_resume", dut_grant, 1);

        // accept+done cancel, underflow sticky
        do_reset();
        s_req_valid = 4'b0100;
        step();
        s_done = 4'b0100;
        step();
        chk("cancel_grant", dut_grant, 2);
        chk("cancel_cnt", outstanding[2], 1);
        s_req_valid = '0;
        s_done = 4'b1000;
        step();
        s_done = '0;
        chk("uf_cnt", outstanding[3], 0);
        chk("uf_flag", err_underflow[3], 1);
        repeat (3) step();
        chk("uf_sticky", err_underflow[3], 1);

        // randomized traffic with a reset in the middle
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c % 32 == 0)
                for (int i = 0; i < N; i++) cfg_weight[i] = WB'($urandom_range(0, 3));
            s_req_valid = N'($urandom);
            for (int i = 0; i < N; i++) s_done[i] = ($urandom_range(0, 5) == 0);
            m_req_ready = ($urandom_range(0, 3) != 0);
            m_mux_ready = ($urandom_range(0, 3) != 0);
            rand_payload();
            if (c == 400) begin
                do_reset();
                cfg_weight = {4'd1, 4'd2, 4'd1, 4'd1};
                s_req_valid = 4'b1100;
                m_req_ready = 1'b1; m_mux_ready = 1'b1;
                step();
                chk("post_rst_first", dut_grant, 2);
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
